// File: rtl/dram_write_sequencer.sv
`default_nettype none
// ============================================================================
// dram_write_sequencer: maps 128-bit AXI-Stream chunks onto DRAM app writes
// Revision: 1.0
// ============================================================================
module dram_write_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 27,
  parameter int unsigned           ADDR_STEP    = 8,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR = 27'h400000,
  parameter int unsigned           FB_CHUNKS    = 38400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  input  logic                  sample_load_complete,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [127:0]          s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [127:0]          app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic                  frame_mode,
  output logic                  frame_done,
  output logic                  sample_overflow,
  output logic                  frame_misalign
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] c_fb_last   =
    FB_BASE_ADDR + ADDR_WIDTH'((FB_CHUNKS - 1) * ADDR_STEP);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_cmd_pend;
  logic                  r_data_pend;
  logic                  r_last;
  logic                  r_frame_mode;
  logic                  r_frame_done;
  logic                  r_sample_overflow;
  logic                  r_frame_misalign;
  logic [ADDR_WIDTH-1:0] r_app_addr;
  logic [ADDR_WIDTH-1:0] r_sample_ptr;
  logic [ADDR_WIDTH-1:0] r_frame_ptr;
  logic [127:0]          r_wdf_data;

  logic w_mode_switch;
  logic w_tready;
  logic w_accept;
  logic w_cmd_pend_nxt;
  logic w_data_pend_nxt;
  logic w_sample_room;
  logic w_sample_last;

  // Mode switch takes priority over a handshake so a chunk never straddles it.
  assign w_mode_switch   = (r_state == ST_IDLE) && !r_frame_mode && sample_load_complete;
  assign w_tready        = (r_state == ST_IDLE) && init_calib_complete && !w_mode_switch;
  assign w_accept        = w_tready && s_axis_tvalid;
  assign w_cmd_pend_nxt  = r_cmd_pend && !app_rdy;
  assign w_data_pend_nxt = r_data_pend && !app_wdf_rdy;
  assign w_sample_room   = (r_sample_ptr < FB_BASE_ADDR);
  assign w_sample_last   = ((FB_BASE_ADDR - r_sample_ptr) <= c_addr_step);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_cmd_pend        <= 1'b0;
      r_data_pend       <= 1'b0;
      r_last            <= 1'b0;
      r_frame_mode      <= 1'b0;
      r_frame_done      <= 1'b0;
      r_sample_overflow <= 1'b0;
      r_frame_misalign  <= 1'b0;
      r_app_addr        <= '0;
      r_sample_ptr      <= '0;
      r_frame_ptr       <= '0;
      r_wdf_data        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_mode_switch) begin
            r_frame_mode <= 1'b1;
            r_frame_ptr  <= FB_BASE_ADDR;
          end else if (w_accept) begin
            r_wdf_data <= s_axis_tdata;
            r_last     <= s_axis_tlast;
            if (r_frame_mode) begin
              r_app_addr  <= r_frame_ptr;
              r_cmd_pend  <= 1'b1;
              r_data_pend <= 1'b1;
              r_state     <= ST_WRITE;
              if (s_axis_tlast) begin
                r_frame_ptr <= FB_BASE_ADDR;
              end else if (r_frame_ptr == c_fb_last) begin
                r_frame_ptr      <= FB_BASE_ADDR;
                r_frame_misalign <= 1'b1;
              end else begin
                r_frame_ptr <= r_frame_ptr + c_addr_step;
              end
            end else if (w_sample_room) begin
              r_app_addr   <= r_sample_ptr;
              r_cmd_pend   <= 1'b1;
              r_data_pend  <= 1'b1;
              r_state      <= ST_WRITE;
              // Clamp so the pointer never steps past the frame-buffer base.
              r_sample_ptr <= w_sample_last ? FB_BASE_ADDR : r_sample_ptr + c_addr_step;
            end else begin
              r_sample_overflow <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_cmd_pend  <= w_cmd_pend_nxt;
          r_data_pend <= w_data_pend_nxt;
          if (!w_cmd_pend_nxt && !w_data_pend_nxt) begin
            r_state      <= ST_IDLE;
            r_frame_done <= r_last && r_frame_mode;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready   = w_tready;
  assign app_addr        = r_app_addr;
  assign app_cmd         = 3'b000;
  assign app_en          = r_cmd_pend;
  assign app_wdf_data    = r_wdf_data;
  assign app_wdf_wren    = r_data_pend;
  assign app_wdf_end     = r_data_pend;
  assign frame_mode      = r_frame_mode;
  assign frame_done      = r_frame_done;
  assign sample_overflow = r_sample_overflow;
  assign frame_misalign  = r_frame_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dram_write_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dram_write_sequencer: directed and random stimulus against a chunk-level model
// Revision: 1.0
// ============================================================================
module tb_dram_write_sequencer;

  localparam int          AW     = 27;
  localparam int          STEP   = 8;
  localparam logic [26:0] FBBASE = 27'd32;
  localparam int          FBN    = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib = 1'b0;
  logic         slc = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tlast = 1'b0;
  logic [AW-1:0] app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy = 1'b1;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy = 1'b1;
  logic         frame_mode;
  logic         frame_done;
  logic         sample_overflow;
  logic         frame_misalign;

  dram_write_sequencer #(
    .ADDR_WIDTH  (AW),
    .ADDR_STEP   (STEP),
    .FB_BASE_ADDR(FBBASE),
    .FB_CHUNKS   (FBN)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (calib),
    .sample_load_complete(slc),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tlast        (s_axis_tlast),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .frame_mode          (frame_mode),
    .frame_done          (frame_done),
    .sample_overflow     (sample_overflow),
    .frame_misalign      (frame_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Chunk-level model: outstanding command/data flags, sample count, frame index.
  bit          m_cmd = 0, m_dat = 0, m_mode = 0, m_ovf = 0, m_mis = 0, m_done = 0, m_last = 0;
  int          m_scount = 0, m_fidx = 0;
  logic [26:0] m_addr = '0;
  logic [127:0] m_data = '0;

  logic [26:0]  cmd_log[$];
  logic [127:0] data_log[$];
  int done_cnt = 0, en_cnt = 0, wren_cnt = 0;

  always @(negedge clk) begin
    bit exp_tready;
    exp_tready = !(m_cmd || m_dat) && calib && !(!m_mode && slc);
    if (chk_en) begin
      check("tready", s_axis_tready, exp_tready);
      check("app_en", app_en, m_cmd);
      check("wdf_wren", app_wdf_wren, m_dat);
      check("wdf_end", app_wdf_end, m_dat);
      check("app_cmd", app_cmd, 3'b000);
      check("frame_mode", frame_mode, m_mode);
      check("frame_done", frame_done, m_done);
      check("sample_overflow", sample_overflow, m_ovf);
      check("frame_misalign", frame_misalign, m_mis);
      if (m_cmd) check("app_addr", app_addr, m_addr);
      if (m_dat) check("wdf_data", app_wdf_data, m_data);
    end
    if (app_en && app_rdy) cmd_log.push_back(app_addr);
    if (app_wdf_wren && app_wdf_rdy) data_log.push_back(app_wdf_data);
    if (frame_done) done_cnt++;
    if (app_en) en_cnt++;
    if (app_wdf_wren) wren_cnt++;
    // Advance the model to the state after the coming edge.
    if (!rst_n) begin
      m_cmd = 0; m_dat = 0; m_mode = 0; m_ovf = 0; m_mis = 0; m_done = 0; m_last = 0;
      m_scount = 0; m_fidx = 0; m_addr = '0; m_data = '0;
    end else begin
      m_done = 0;
      if (m_cmd || m_dat) begin
        if (app_rdy) m_cmd = 0;
        if (app_wdf_rdy) m_dat = 0;
        if (!m_cmd && !m_dat) m_done = m_last && m_mode;
      end else if (!m_mode && slc) begin
        m_mode = 1;
        m_fidx = 0;
      end else if (s_axis_tvalid && exp_tready) begin
        m_data = s_axis_tdata;
        m_last = s_axis_tlast;
        if (!m_mode) begin
          if (m_scount * STEP < int'(FBBASE)) begin
            m_addr = 27'(m_scount * STEP);
            m_scount++;
            m_cmd = 1; m_dat = 1;
          end else begin
            m_ovf = 1;
          end
        end else begin
          m_addr = FBBASE + 27'(m_fidx * STEP);
          m_cmd = 1; m_dat = 1;
          if (s_axis_tlast) m_fidx = 0;
          else if (m_fidx == FBN - 1) begin m_fidx = 0; m_mis = 1; end
          else m_fidx++;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic l);
    bit ok;
    ok = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_axis_tready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_tready required=tready data=%0h", d);
    end
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, e0, w0, d0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    calib = 1'b1;

    // Three sample chunks at full rate.
    n0 = cmd_log.size();
    d0 = done_cnt;
    send(128'd1, 1'b0);
    send(128'd2, 1'b0);
    send(128'd3, 1'b0);
    settle();
    check("sample_cnt", 128'(cmd_log.size() - n0), 128'd3);
    for (int i = 0; i < 3; i++) begin
      check("sample_addr", cmd_log[n0 + i], 128'(8 * i));
      check("sample_data", data_log[n0 + i], 128'(i + 1));
    end
    check("sample_done_none", 128'(done_cnt - d0), 128'd0);

    // Command stalled for four cycles, data accepted at once.
    app_rdy = 1'b0;
    n0 = cmd_log.size();
    e0 = en_cnt;
    w0 = wren_cnt;
    send(128'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1 app_rdy = 1'b1;
    settle();
    check("stall_en_cycles", 128'(en_cnt - e0), 128'd5);
    check("stall_wren_cycles", 128'(wren_cnt - w0), 128'd1);
    check("stall_addr", cmd_log[n0], 128'd24);

    // Sample region full: further chunks are dropped.
    n0 = cmd_log.size();
    send(128'd5, 1'b0);
    send(128'd6, 1'b0);
    settle();
    check("overflow_flag", sample_overflow, 1'b1);
    check("overflow_no_cmd", 128'(cmd_log.size() - n0), 128'd0);

    // Reset while a write is stalled; transfer is abandoned.
    pulse_reset();
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    send(128'd7, 1'b0);
    pulse_reset();
    @(negedge clk);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_overflow", sample_overflow, 1'b0);
    @(posedge clk);
    #1 app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    n0 = cmd_log.size();
    send(128'd8, 1'b0);
    settle();
    check("post_rst_addr", cmd_log[n0], 128'd0);
    check("post_rst_data", data_log[n0], 128'd8);

    // Frame mode: two full frames.
    slc = 1'b1;
    settle();
    check("frame_mode_on", frame_mode, 1'b1);
    n0 = cmd_log.size();
    d0 = done_cnt;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FBN; i++) send(128'(100 + i), i == FBN - 1);
    settle();
    for (int k = 0; k < 2 * FBN; k++)
      check("frame_addr", cmd_log[n0 + k], 128'(32 + 8 * (k % FBN)));
    check("frame_done_cnt", 128'(done_cnt - d0), 128'd2);
    check("frame_no_misalign", frame_misalign, 1'b0);

    // Short frame: tlast after five chunks.
    n0 = cmd_log.size();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send(128'(200 + i), i == 4);
    send(128'd205, 1'b0);
    settle();
    check("short_restart_addr", cmd_log[n0 + 5], 128'd32);
    check("short_done_cnt", 128'(done_cnt - d0), 128'd1);
    check("short_no_misalign", frame_misalign, 1'b0);

    // Pointer wraps without tlast (frame index now 1).
    n0 = cmd_log.size();
    for (int i = 0; i < FBN; i++) send(128'(300 + i), 1'b0);
    settle();
    check("wrap_addr", cmd_log[n0 + FBN - 1], 128'd32);
    check("wrap_misalign", frame_misalign, 1'b1);

    // Random traffic, backpressure and a mid-run reset.
    slc = 1'b0;
    pulse_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      app_rdy       = ($urandom_range(0, 9) < 7);
      app_wdf_rdy   = ($urandom_range(0, 9) < 7);
      calib         = ($urandom_range(0, 9) != 0);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = ($urandom_range(0, 7) == 0);
      if (c == 1500) slc = 1'b1;
      rst_n = !(c == 2800);
    end
    s_axis_tvalid = 1'b0;
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
